// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the 1x4 demux scheduler.
`timescale 1ns/1ps
package demux_sched_pkg;

    localparam int NCH = 4;
    localparam int SW  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_HOLD = 2'd2
    } demux_state_e;

    function automatic logic [NCH-1:0] onehot(input logic [SW-1:0] idx);
        logic [NCH-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/demux_scheduler_rr_pick.sv
// Rotating-priority picker: first set mask bit at or above ptr, wrapping modulo NCH.
`timescale 1ns/1ps
module rr_pick
    import demux_sched_pkg::*;
(
    input  logic [NCH-1:0] chan_mask,
    input  logic [SW-1:0]  ptr,
    output logic [SW-1:0]  grant,
    output logic           any_set
);

    logic [SW-1:0] idx;

    // Scan from the farthest offset down so the nearest eligible channel wins.
    always_comb begin
        grant   = ptr;
        any_set = |chan_mask;
        idx     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = ptr + SW'(i);
            if (chan_mask[idx]) begin
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/demux_scheduler.sv
// Round-robin 1x4 beat demux with a single registered output slot shared by all channels.
`timescale 1ns/1ps
module demux_scheduler
    import demux_sched_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [NCH-1:0] chan_mask,
    input  logic [DW-1:0]  din,
    input  logic           din_valid,
    output logic           din_ready,
    output logic [DW-1:0]  dout,
    output logic [NCH-1:0] dout_valid,
    input  logic [NCH-1:0] dout_ready,
    output logic [SW-1:0]  s,
    output logic           busy,
    output demux_state_e   state_dbg
);

    // Handshake: a beat moves on any rising edge where valid and ready are both high;
    // ready never looks at valid, and the output side holds dout/s/dout_valid until
    // dout_ready[s] is seen.

    demux_state_e   state_q;
    logic [SW-1:0]  ptr_q;
    logic [SW-1:0]  s_q;
    logic [DW-1:0]  dout_q;
    logic [NCH-1:0] dout_valid_q;

    logic [SW-1:0]  grant;
    logic           any_set;
    logic [SW-1:0]  ptr_d;
    logic           can_grant;
    logic           hold_done;
    logic           xfer;

    rr_pick u_rr_pick (
        .chan_mask (chan_mask),
        .ptr       (ptr_q),
        .grant     (grant),
        .any_set   (any_set)
    );

    assign can_grant = en & any_set;
    assign hold_done = (state_q == S_HOLD) & dout_ready[s_q];
    assign din_ready = can_grant & ((state_q == S_ARB) | hold_done);
    assign xfer      = din_valid & din_ready;
    assign ptr_d     = grant + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            s_q          <= '0;
            dout_q       <= '0;
            dout_valid_q <= '0;
        end else if (xfer) begin
            // Covers both a fresh grant from ARB and back-to-back reload in HOLD.
            state_q      <= S_HOLD;
            dout_q       <= din;
            s_q          <= grant;
            dout_valid_q <= onehot(grant);
            ptr_q        <= ptr_d;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (can_grant) state_q <= S_ARB;
                end
                S_ARB: begin
                    if (!can_grant) state_q <= S_IDLE;
                end
                S_HOLD: begin
                    if (hold_done) begin
                        dout_valid_q <= '0;
                        state_q      <= can_grant ? S_ARB : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign s          = s_q;
    assign busy       = (state_q == S_HOLD);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_demux_scheduler.sv
// Scoreboard bench for demux_scheduler: random and directed beats against a queue-based reference.
`timescale 1ns/1ps
module tb_demux_scheduler;
  import demux_sched_pkg::*;

  localparam int DW = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          en;
  logic [3:0]    chan_mask;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic [3:0]    dout_valid;
  logic [3:0]    dout_ready;
  logic [1:0]    s;
  logic          busy;
  demux_state_e  state_dbg;

  demux_scheduler #(.DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .chan_mask  (chan_mask),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .s          (s),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [DW+1:0] exp_q[$];  // {channel, data}

  // reference model: phase of the output slot, rotation pointer, held channel
  demux_state_e m_phase = S_IDLE;
  int m_ptr  = 0;
  int m_held = 0;

  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) begin
      if (m[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one clock cycle of stimulus, per-cycle checks, then model advance
  task automatic step(input logic e, input logic [3:0] m, input logic v,
                      input logic [DW-1:0] d, input logic [3:0] r);
    logic rdy_exp;
    logic [DW+1:0] head;
    int g;
    @(negedge clk);
    en = e; chan_mask = m; din_valid = v; din = d; dout_ready = r;
    #1;
    rdy_exp = e && (m != 4'd0) &&
              (m_phase == S_ARB || (m_phase == S_HOLD && r[m_held]));
    check("din_ready", 32'(din_ready), 32'(rdy_exp));
    check("busy", 32'(busy), 32'(m_phase == S_HOLD));
    check("state", 32'(state_dbg), 32'(m_phase));
    check("dout_valid", 32'(dout_valid),
          (m_phase == S_HOLD) ? (32'd1 << m_held) : 32'd0);
    if (m_phase == S_HOLD && exp_q.size() > 0) begin
      head = exp_q[0];
      check("held_dout", 32'(dout), 32'(head[DW-1:0]));
      check("held_s", 32'(s), 32'(head[DW+1:DW]));
    end
    @(posedge clk);
    if (v && rdy_exp) begin
      g = pick(m, m_ptr);
      exp_q.push_back({2'(g), d});
      m_held  = g;
      m_ptr   = (g + 1) % 4;
      m_phase = S_HOLD;
    end else if (m_phase == S_HOLD) begin
      if (r[m_held]) m_phase = (e && m != 4'd0) ? S_ARB : S_IDLE;
    end else if (m_phase == S_IDLE) begin
      if (e && m != 4'd0) m_phase = S_ARB;
    end else if (!(e && m != 4'd0)) begin
      m_phase = S_IDLE;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; din_valid = 1'b0; dout_ready = 4'd0;
    #1;
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    exp_q.delete();
    m_phase = S_IDLE; m_ptr = 0; m_held = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'hF, 1'b0, '0, 4'hF);
  endtask

  // monitor: pop on every delivery the DUT presents
  always @(negedge clk) begin
    logic [DW+1:0] e;
    #2;
    if (rst_n === 1'b1 && dout_valid != 4'd0 && dout_ready[s]) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_delivery: got ch %0d data %0h expected none at %0t",
                 s, dout, $time);
      end else begin
        e = exp_q.pop_front();
        check("deliver_s", 32'(s), 32'(e[DW+1:DW]));
        check("deliver_dout", 32'(dout), 32'(e[DW-1:0]));
        check("deliver_onehot", 32'(dout_valid), 32'd1 << e[DW+1:DW]);
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; chan_mask = 4'd0; din = '0;
    din_valid = 1'b0; dout_ready = 4'd0;
    do_reset();

    // back-to-back beats, all channels eligible
    step(1'b1, 4'hF, 1'b0, '0, 4'hF);
    for (int i = 0; i < 5; i++) step(1'b1, 4'hF, 1'b1, DW'(8'h10 + i), 4'hF);
    drain(2);

    // alternating channels 1 and 3
    for (int i = 0; i < 4; i++) step(1'b1, 4'b1010, 1'b1, DW'($urandom_range(0, 255)), 4'hF);
    drain(2);

    // hold on channel 2 while other ready bits are high
    step(1'b1, 4'b0100, 1'b1, 8'hA5, 4'b0001);
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0100, 1'b1, 8'h77, 4'b0001);
    step(1'b1, 4'b0100, 1'b0, '0, 4'b0100);
    drain(2);

    // held channel masked off mid-hold, then next grant rotates onward
    step(1'b1, 4'b0100, 1'b1, 8'hA5, 4'b0000);
    step(1'b1, 4'b1011, 1'b0, '0, 4'b0000);
    step(1'b1, 4'b1011, 1'b0, '0, 4'b0100);
    step(1'b1, 4'b1011, 1'b1, 8'h3C, 4'hF);
    drain(2);

    // enable drops while holding
    step(1'b1, 4'hF, 1'b1, 8'h5A, 4'b0000);
    step(1'b0, 4'hF, 1'b1, 8'h66, 4'b0000);
    step(1'b0, 4'hF, 1'b1, 8'h66, 4'hF);
    step(1'b0, 4'hF, 1'b1, 8'h66, 4'hF);

    // reset in the middle of a hold
    step(1'b1, 4'hF, 1'b0, '0, 4'hF);
    step(1'b1, 4'b0010, 1'b1, 8'h99, 4'b0000);
    step(1'b1, 4'b0010, 1'b0, '0, 4'b0000);
    do_reset();
    step(1'b1, 4'hF, 1'b0, '0, 4'hF);
    step(1'b1, 4'hF, 1'b1, 8'h42, 4'hF);
    drain(2);

    // empty mask never accepts
    for (int i = 0; i < 10; i++) step(1'b1, 4'b0000, 1'b1, 8'hEE, 4'hF);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(($urandom_range(0, 9) != 0),
           ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0),
           DW'($urandom_range(0, 255)),
           4'($urandom_range(0, 15)));
    end

    drain(4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_scheduler.md
DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

Interface
REQ-001 Parameter: DW, default 8, width of the data beat routed to the four channels.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  scheduler enable; 0 = accept no new beats.
REQ-005 chan_mask  input  4  per-channel enable; bit i = channel i eligible for grant.
REQ-006 din  input  DW  input beat data.
REQ-007 din_valid  input  1  input beat present.
REQ-008 din_ready  output  1  scheduler accepts din this cycle.
REQ-009 dout  output  DW  registered beat data, shared by all channels.
REQ-010 dout_valid  output  4  one-hot; bit i = dout is addressed to channel i.
REQ-011 dout_ready  input  4  bit i = channel i consumes dout this cycle.
REQ-012 s  output  2  registered channel select (3..0), drives the 1x4 demux select.
REQ-013 busy  output  1  high while a beat is held in the output register.

Function
REQ-014 FSM states: IDLE, ARB, HOLD, encoded in the shared package.
REQ-015 IDLE -> ARB when en=1 and chan_mask!=0; ARB -> IDLE when en=0 or chan_mask=0.
REQ-016 Grant: the first set chan_mask bit searching from ptr upward (ptr, ptr+1, ... mod 4); dout_ready is NOT considered.
REQ-017 din_ready = en & (chan_mask!=0) & (state==ARB | (state==HOLD & dout_ready[s])); combinational, no dependence on din_valid.
REQ-018 Transfer on din_valid & din_ready: din registered into dout, s <= grant, dout_valid <= one-hot(grant), ptr <= grant+1 (3 wraps to 0), state <= HOLD.
REQ-019 Latency: beat accepted on edge N is presented on dout/dout_valid/s from edge N, i.e. visible the cycle after acceptance.
REQ-020 HOLD: dout, s, dout_valid stable until dout_ready[s]=1; dout_ready bits of non-granted channels ignored.
REQ-021 HOLD with dout_ready[s]=1 and a simultaneous new transfer: new beat loaded same edge, stays HOLD (throughput one beat/cycle).
REQ-022 HOLD with dout_ready[s]=1 and no new transfer: dout_valid <= 0, state <= ARB (or IDLE if en=0 or chan_mask=0); dout and s retain last value.
REQ-023 Mask bit of the held channel cleared during HOLD: held beat still delivered to that channel; mask applies only to the next grant.
REQ-024 en falls during HOLD: held beat completes normally, no further accepts, then IDLE.
REQ-025 chan_mask single bit set: every beat granted to that channel; ptr still advances per REQ-018.
REQ-026 busy = (state==HOLD).

Reset
REQ-027 rst_n low: state=IDLE, ptr=0, s=0, dout=0, dout_valid=0, busy=0, din_ready=0, asynchronously.
REQ-028 Reset during HOLD discards the held beat; no dout_valid after release until a new transfer.
REQ-029 First grant after reset release searches from channel 0.

Structure
REQ-030 Package demux_sched_pkg holds the state enum, NCH=4, and the select width 2.
REQ-031 Sub-module rr_pick: combinational, inputs chan_mask and ptr, outputs grant[1:0] and any_set; instantiated once.
REQ-032 ptr, s, dout, dout_valid, state are the only registers.

Verification
REQ-033 Mask 4'b1111, en=1, all dout_ready=1, beats 0x10,0x11,0x12,0x13,0x14 back-to-back -> s=0,1,2,3,0, one beat per cycle, din_ready held 1.
REQ-034 Mask 4'b1010, four beats -> s=1,3,1,3; dout_valid=4'b0010,4'b1000 alternating.
REQ-035 Beat 0xA5 to channel 2, dout_ready[2]=0 for 5 cycles, dout_ready[0]=1 -> dout=0xA5, dout_valid=4'b0100 stable 5 cycles, din_ready=0; released on cycle dout_ready[2]=1.
REQ-036 Channel 2 holding, chan_mask goes 4'b1011 then dout_ready[2]=1 -> 0xA5 delivered to channel 2; next beat granted to channel 3.
REQ-037 rst_n low mid-HOLD for 1 cycle -> dout_valid=0 immediately, s=0; next beat after release granted to channel 0.
REQ-038 chan_mask=0 with din_valid=1 -> din_ready=0, state IDLE, no dout_valid for 10 cycles.
